// File: rtl/sisc_pkg.sv
// Shared SISC definitions: instruction opcodes, instruction field positions
// and the fetch-stage state encoding.
package sisc_pkg;

   localparam logic [3:0] NOOP   = 4'd0;
   localparam logic [3:0] LOD    = 4'd1;
   localparam logic [3:0] STR    = 4'd2;
   localparam logic [3:0] SWP    = 4'd3;
   localparam logic [3:0] BRA    = 4'd4;
   localparam logic [3:0] BRR    = 4'd5;
   localparam logic [3:0] BNE    = 4'd6;
   localparam logic [3:0] BNR    = 4'd7;
   localparam logic [3:0] ALU_OP = 4'd8;
   localparam logic [3:0] HLT    = 4'd15;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;
   localparam int MM_HI  = 27;
   localparam int MM_LO  = 24;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int IMM_W  = IMM_HI - IMM_LO + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/fetch_unit_br_target.sv
// Branch resolver: decides whether the instruction in IR takes its branch
// and computes the resulting program counter.
module br_target
   import sisc_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [3:0]       opcode,
   input  logic [3:0]       mm,
   input  logic [3:0]       stat,
   input  logic [IMM_W-1:0] imm,
   input  logic [PC_W-1:0]  pc,
   output logic             taken,
   output logic [PC_W-1:0]  target
);

   logic                   cond;
   logic signed [IMM_W-1:0] imm_s;
   logic signed [PC_W-1:0]  off;
   logic [PC_W-1:0]         abs_tgt;
   logic [PC_W-1:0]         rel_tgt;

   // Relative targets wrap modulo 2^PC_W; negative offsets come from sign extension.
   assign cond    = |(stat & mm);
   assign imm_s   = imm;
   assign off     = PC_W'(imm_s);
   assign abs_tgt = PC_W'(imm);
   assign rel_tgt = pc + $unsigned(off);

   always_comb begin
      taken  = 1'b0;
      target = pc;
      case (opcode)
         BRA: begin taken = cond;  target = abs_tgt; end
         BRR: begin taken = cond;  target = rel_tgt; end
         BNE: begin taken = !cond; target = abs_tgt; end
         BNR: begin taken = !cond; target = rel_tgt; end
         default: begin taken = 1'b0; target = pc; end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// SISC instruction-fetch stage: PC/IR registers, instruction-memory handshake,
// branch resolution on pc_write and sticky halt on HLT.
module fetch_unit
   import sisc_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               fetch_req,
   input  logic               pc_write,
   input  logic [3:0]         stat,
   fetch_unit_if.master       imem,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [PC_W-1:0]    pc,
   output logic               fetch_done,
   output logic               halted,
   output logic               seq_err
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_d;
   logic [INSTR_W-1:0] ir_d;
   logic               req_q, req_d;
   logic [PC_W-1:0]    addr_q, addr_d;
   logic               done_d;
   logic               seq_d;
   logic               br_taken;
   logic [PC_W-1:0]    br_pc;

   assign opcode         = ir[OPC_HI:OPC_LO];
   assign mm             = ir[MM_HI:MM_LO];
   assign halted         = (state_q == HALT);
   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;

   br_target #(.PC_W(PC_W)) u_br_target (
      .opcode (opcode),
      .mm     (mm),
      .stat   (stat),
      .imm    (ir[IMM_HI:IMM_LO]),
      .pc     (pc),
      .taken  (br_taken),
      .target (br_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      ir_d    = ir;
      req_d   = req_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      seq_d   = seq_err;
      case (state_q)
         IDLE: begin
            // Branch resolution wins; a held fetch_req is picked up next cycle.
            if (pc_write) begin
               if (br_taken) pc_d = br_pc;
            end else if (fetch_req) begin
               req_d   = 1'b1;
               addr_d  = pc;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (pc_write) seq_d = 1'b1;
            if (imem.imem_ack) begin
               ir_d    = imem.imem_rdata;
               pc_d    = pc + PC_W'(1);
               req_d   = 1'b0;
               done_d  = 1'b1;
               state_d = (imem.imem_rdata[OPC_HI:OPC_LO] == HLT) ? HALT : IDLE;
            end
         end
         HALT: begin
            req_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q    <= IDLE;
         pc         <= '0;
         ir         <= '0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fetch_done <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc         <= pc_d;
         ir         <= ir_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fetch_done <= done_d;
         seq_err    <= seq_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch handshake, branch
// resolution, PC wrap, sequencing error, halt and reset behaviour.
module tb_fetch_unit;

   logic        clk;
   logic        rst_f;
   logic        fetch_req;
   logic        pc_write;
   logic [3:0]  stat;
   logic [31:0] ir;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic [15:0] pc;
   logic        fetch_done;
   logic        halted;
   logic        seq_err;

   int errors = 0;
   int checks = 0;

   fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem ();

   fetch_unit #(.PC_W(16), .INSTR_W(32)) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .fetch_req  (fetch_req),
      .pc_write   (pc_write),
      .stat       (stat),
      .imem       (imem),
      .ir         (ir),
      .opcode     (opcode),
      .mm         (mm),
      .pc         (pc),
      .fetch_done (fetch_done),
      .halted     (halted),
      .seq_err    (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: raise fetch_req, wait `waits` cycles with the request up,
   // then ack with `data`. Returns the sampled address and whether req held.
   task automatic fetch(input logic [31:0] data, input int waits,
                        output logic [15:0] addr_seen, output logic req_ok);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      req_ok    = imem.imem_req;
      addr_seen = imem.imem_addr;
      for (int i = 0; i < waits; i++) begin
         tick();
         req_ok = req_ok & imem.imem_req;
      end
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = data;
      tick();
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
   endtask

   task automatic pulse_pc_write(input logic [3:0] s);
      stat     = s;
      pc_write = 1'b1;
      tick();
      pc_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_f = 1'b1;
      tick();
      tick();
      rst_f = 1'b0;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
      checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); end
      checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem.imem_req); end
      checks++; if ({fetch_done, halted, seq_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {fetch_done, halted, seq_err}); end
   endtask

   task automatic test_fetch();
      logic [15:0] a;
      logic        ok;
      fetch(32'h8800_0001, 2, a, ok);
      checks++; if (a !== 16'h0000) begin errors++; $display("FAIL fetch_addr got=%h exp=%h", a, 16'h0000); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fetch_req_held got=%b exp=1", ok); end
      checks++; if (ir !== 32'h8800_0001) begin errors++; $display("FAIL fetch_ir got=%h exp=%h", ir, 32'h8800_0001); end
      checks++; if ({opcode, mm} !== 8'h88) begin errors++; $display("FAIL fetch_fields got=%h exp=%h", {opcode, mm}, 8'h88); end
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", pc, 16'h0001); end
      checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL fetch_done_hi got=%b exp=1", fetch_done); end
      tick();
      checks++; if ({fetch_done, imem.imem_req} !== 2'b00) begin errors++; $display("FAIL fetch_done_lo got=%b exp=00", {fetch_done, imem.imem_req}); end
   endtask

   task automatic test_brr();
      logic [15:0] a;
      logic        ok;
      for (int i = 1; i < 4; i++) fetch(32'h0000_0000, 0, a, ok);
      fetch(32'h5200_FFFE, 1, a, ok);
      checks++; if ({a, pc} !== {16'h0004, 16'h0005}) begin errors++; $display("FAIL brr_setup got=%h exp=%h", {a, pc}, {16'h0004, 16'h0005}); end
      pulse_pc_write(4'b0001);
      checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL brr_not_taken got=%h exp=%h", pc, 16'h0005); end
      pulse_pc_write(4'b0010);
      checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL brr_taken got=%h exp=%h", pc, 16'h0003); end
   endtask

   task automatic test_bne();
      logic [15:0] a;
      logic        ok;
      fetch(32'h6100_0040, 0, a, ok);
      checks++; if ({a, pc} !== {16'h0003, 16'h0004}) begin errors++; $display("FAIL bne_setup got=%h exp=%h", {a, pc}, {16'h0003, 16'h0004}); end
      pulse_pc_write(4'b0001);
      checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL bne_not_taken got=%h exp=%h", pc, 16'h0004); end
      pulse_pc_write(4'b0000);
      checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL bne_taken got=%h exp=%h", pc, 16'h0040); end
   endtask

   task automatic test_bnr();
      logic [15:0] a;
      logic        ok;
      fetch(32'h7300_FFF0, 0, a, ok);
      pulse_pc_write(4'b0001);
      checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL bnr_not_taken got=%h exp=%h", pc, 16'h0041); end
      pulse_pc_write(4'b0100);
      checks++; if (pc !== 16'h0031) begin errors++; $display("FAIL bnr_taken got=%h exp=%h", pc, 16'h0031); end
   endtask

   task automatic test_wrap_priority();
      logic [15:0] a;
      logic        ok;
      fetch(32'h4F00_FFFF, 0, a, ok);
      // pc_write and fetch_req together: branch applies, fetch waits a cycle
      stat      = 4'b0001;
      pc_write  = 1'b1;
      fetch_req = 1'b1;
      tick();
      pc_write  = 1'b0;
      checks++; if ({pc, imem.imem_req} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL prio_branch got=%h exp=%h", {pc, imem.imem_req}, {16'hFFFF, 1'b0}); end
      tick();
      fetch_req = 1'b0;
      checks++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL prio_fetch got=%h exp=%h", {imem.imem_req, imem.imem_addr}, {1'b1, 16'hFFFF}); end
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'h0000_0000;
      tick();
      imem.imem_ack   = 1'b0;
      checks++; if ({pc, fetch_done} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", {pc, fetch_done}, {16'h0000, 1'b1}); end
   endtask

   task automatic test_seq_err_reset();
      logic [15:0] a;
      logic        ok;
      fetch(32'h4100_0077, 0, a, ok);
      stat      = 4'b0001;
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      pc_write  = 1'b1;
      tick();
      pc_write  = 1'b0;
      checks++; if ({pc, seq_err, imem.imem_req} !== {16'h0001, 2'b11}) begin errors++; $display("FAIL seq_err got=%h exp=%h", {pc, seq_err, imem.imem_req}, {16'h0001, 2'b11}); end
      rst_f           = 1'b1;
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'h1234_5678;
      tick();
      rst_f           = 1'b0;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
      checks++; if ({ir, pc} !== {32'h0, 16'h0000}) begin errors++; $display("FAIL rst_ack_regs got=%h exp=%h", {ir, pc}, {32'h0, 16'h0000}); end
      checks++; if ({imem.imem_req, fetch_done, seq_err} !== 3'b000) begin errors++; $display("FAIL rst_ack_flags got=%b exp=000", {imem.imem_req, fetch_done, seq_err}); end
      fetch(32'h1111_2222, 0, a, ok);
      checks++; if ({a, pc, ir} !== {16'h0000, 16'h0001, 32'h1111_2222}) begin errors++; $display("FAIL rst_idle_fetch got=%h exp=%h", {a, pc, ir}, {16'h0000, 16'h0001, 32'h1111_2222}); end
   endtask

   task automatic test_halt();
      logic [15:0] a;
      logic        ok;
      logic        req_seen;
      fetch(32'hF000_0000, 0, a, ok);
      checks++; if ({halted, pc} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL halt_set got=%h exp=%h", {halted, pc}, {1'b1, 16'h0002}); end
      req_seen  = 1'b0;
      fetch_req = 1'b1;
      pc_write  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         req_seen = req_seen | imem.imem_req;
      end
      fetch_req = 1'b0;
      pc_write  = 1'b0;
      checks++; if ({req_seen, halted, pc} !== {2'b01, 16'h0002}) begin errors++; $display("FAIL halt_frozen got=%h exp=%h", {req_seen, halted, pc}, {2'b01, 16'h0002}); end
      rst_f = 1'b1;
      tick();
      rst_f = 1'b0;
      checks++; if ({halted, pc} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL halt_reset got=%h exp=%h", {halted, pc}, {1'b0, 16'h0000}); end
   endtask

   initial begin
      rst_f           = 1'b1;
      fetch_req       = 1'b0;
      pc_write        = 1'b0;
      stat            = 4'b0000;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
      test_reset();
      test_fetch();
      test_brr();
      test_bne();
      test_bnr();
      test_wrap_priority();
      test_seq_err_reset();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
